data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter LINE_BYTES, default 16: cache line size in bytes, four 32-bit words.
REQ-002 The block SHALL have parameter NUM_SETS, default 16: number of direct-mapped sets.
REQ-003 The block SHALL have these ports, and they SHALL be as listed:
  clk  in  1  clock
  reset  in  1  reset, synchronous, active-high
  req_valid  in  1  CPU request present
  req_read  in  1  CPU load
  req_write  in  1  CPU store
  req_addr  in  32  byte address, word-aligned
  req_wdata  in  32  store data
  ready  out  1  cache can accept a request this cycle
  resp_valid  out  1  one-cycle response pulse
  resp_rdata  out  32  load data, valid with resp_valid
  resp_hit  out  1  1 = request hit on first lookup, valid with resp_valid
  mem_req_valid  out  1  backing-memory request
  mem_req_write  out  1  1 = line writeback, 0 = line fill
  mem_req_addr  out  32  line-aligned address
  mem_req_wdata  out  128  writeback line data
  mem_req_ready  in  1  memory accepts request
  mem_rdata_valid  in  1  fill data present
  mem_rdata  in  128  fill line data
  hit_count  out  32  accesses that hit
  miss_count  out  32  accesses that missed

Function
REQ-004 Address split SHALL be: word offset = addr[3:2]; index = addr[7:4]; tag = addr[31:8]. The cache SHALL be direct-mapped, write-back and write-allocate.
REQ-005 The FSM SHALL have the states IDLE, COMPARE, WRITEBACK, FILL_REQ and FILL_WAIT.
REQ-006 In IDLE, ready SHALL be 1. A request SHALL be accepted when req_valid && ready && (req_read || req_write) at a rising edge. On acceptance, the block SHALL latch addr, wdata and op, clear the miss flag, and go to COMPARE.
REQ-007 If req_read and req_write are both 1, the request SHALL be treated as a write. A request with neither set SHALL be ignored. A request while ready=0 SHALL be ignored.
REQ-008 In COMPARE, a hit (valid && tag match) SHALL raise resp_valid=1 for exactly that cycle, with resp_rdata = the addressed word and resp_hit = !miss_flag. A write hit SHALL update the word and set dirty at that edge. The FSM SHALL then return to IDLE. Hit latency SHALL be 1 cycle after acceptance.
REQ-009 In COMPARE, a miss SHALL set miss_flag. If the victim line is valid and dirty, the FSM SHALL go to WRITEBACK; otherwise it SHALL go to FILL_REQ.
REQ-010 In WRITEBACK, the block SHALL drive mem_req_valid=1, mem_req_write=1, mem_req_addr={victim tag, index, 4'b0} and mem_req_wdata=victim line. These SHALL be held stable until mem_req_ready=1 at an edge, after which the FSM SHALL go to FILL_REQ.
REQ-011 In FILL_REQ, the block SHALL drive mem_req_valid=1, mem_req_write=0 and mem_req_addr={req tag, index, 4'b0}, held until mem_req_ready=1. It SHALL then go to FILL_WAIT.
REQ-012 In FILL_WAIT, mem_req_valid SHALL be 0. On mem_rdata_valid=1, the block SHALL write the line, set tag, set valid=1, clear dirty, and go to COMPARE. That lookup SHALL hit and respond with resp_hit=0.
REQ-013 mem_rdata_valid outside FILL_WAIT and mem_req_ready outside WRITEBACK/FILL_REQ SHALL be ignored.
REQ-014 Line word w SHALL occupy bits [32w+31:32w] of the 128-bit line.
REQ-015 hit_count SHALL increment by 1 on each response with resp_hit=1. miss_count SHALL increment by 1 on each COMPARE miss of a first lookup, counted once per access. Both SHALL wrap modulo 2^32.
REQ-016 resp_valid SHALL never be asserted outside COMPARE. The block SHALL hold at most one request in flight.

Reset
REQ-017 When reset=1 at an edge, the FSM SHALL go to IDLE and all valid and dirty bits SHALL clear. Dirty data SHALL be discarded, with no writeback.
REQ-018 The reset values of the outputs SHALL be: ready=1, resp_valid=0, resp_rdata=0, resp_hit=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0, hit_count=0, miss_count=0.
REQ-019 A reset asserted in WRITEBACK, FILL_REQ or FILL_WAIT SHALL drop mem_req_valid the cycle after, and SHALL ignore any later mem_rdata_valid.

Verification
REQ-020 Cold read miss: after reset, read 0x0000_0104, with memory returning line {D3,D2,D1,D0}. Required: one fill request with addr 0x0000_0100; resp_rdata=D1, resp_hit=0; miss_count=1.
REQ-021 Read hit: repeat the REQ-020 read. Required: resp_valid 1 cycle after acceptance, resp_rdata=D1, resp_hit=1, hit_count=1, no mem request.
REQ-022 Write hit then dirty eviction: write 0xDEADBEEF to 0x104, then read 0x1104 (same index, other tag). Required: a writeback to 0x100 with word1=0xDEADBEEF, then a fill of 0x1100, in that order.
REQ-023 Handshake hold: stall mem_req_ready low for 5 cycles. Required: mem_req_valid, addr and wdata stay stable; ready=0 throughout; req_valid during the miss is ignored.
REQ-024 Reset mid-fill: assert reset in FILL_WAIT, then pulse mem_rdata_valid. Required: no response, all lines invalid, and a subsequent read of the same address misses.
REQ-025 Both read and write set on one request: write semantics apply; read with neither bit set produces no response.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// One request in flight at a time; line fills and writebacks move whole
// lines over a simple valid/ready request channel.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_*                 CPU request (valid/read/write/addr/wdata)
//   ready                 high only in IDLE, when a request can be accepted
//   resp_valid/rdata/hit  one-cycle response; hit=1 when the first lookup hit
//   mem_req_*             line writeback (write=1) or fill request (write=0)
//   mem_rdata_valid/rdata fill data returned by memory
//   hit_count/miss_count  wrapping 32-bit access statistics
module data_cache #(
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_read,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    ready,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_hit,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [31:0]             mem_req_addr,
    output logic [LINE_BYTES*8-1:0] mem_req_wdata,
    input  logic                    mem_req_ready,
    input  logic                    mem_rdata_valid,
    input  logic [LINE_BYTES*8-1:0] mem_rdata,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT} state_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    function automatic logic [WSEL_W-1:0] word_of(input logic [31:0] a);
        return a[2 +: WSEL_W];
    endfunction

    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                             input logic [WSEL_W-1:0] w);
        return line[{w, 5'b0} +: 32];
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
    logic                write_q, write_d, miss_q, miss_d;
    logic                ready_q, ready_d, resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                mem_req_valid_q, mem_req_valid_d, mem_req_write_q, mem_req_write_d;
    logic [31:0]         mem_req_addr_q, mem_req_addr_d;
    logic [LINE_W-1:0]   mem_req_wdata_q, mem_req_wdata_d;
    logic [31:0]         hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];
    logic                fill_we, word_we;
    logic [IDX_W-1:0]    req_idx, cur_idx;
    logic                unused_addr_bits;

    assign req_idx = idx_of(req_addr);
    assign cur_idx = idx_of(addr_q);
    assign unused_addr_bits = ^{req_addr[1:0], addr_q[1:0]};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        write_d         = write_q;
        miss_d          = miss_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        resp_hit_d      = resp_hit_q;
        mem_req_write_d = mem_req_write_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        fill_we         = 1'b0;
        word_we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q && (req_read || req_write)) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;   // read+write together behaves as a write
                    miss_d  = 1'b0;
                    state_d = COMPARE;
                    // The tag lookup is done here so the COMPARE-cycle response
                    // comes straight from registers; nothing can change the
                    // arrays between acceptance and COMPARE.
                    if (valid_q[req_idx] && tag_q[req_idx] == tag_of(req_addr)) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = word_sel(data_q[req_idx], word_of(req_addr));
                        resp_hit_d   = 1'b1;
                    end
                end
            end
            COMPARE: begin
                if (resp_valid_q) begin
                    state_d = IDLE;
                    if (write_q) begin
                        word_we          = 1'b1;
                        dirty_d[cur_idx] = 1'b1;
                    end
                    if (resp_hit_q) hit_count_d = hit_count_q + 32'd1;
                end else begin
                    miss_d = 1'b1;
                    if (!miss_q) miss_count_d = miss_count_q + 32'd1;
                    if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
                        state_d         = WRITEBACK;
                        mem_req_write_d = 1'b1;
                        mem_req_addr_d  = {tag_q[cur_idx], cur_idx, {OFF_W{1'b0}}};
                        mem_req_wdata_d = data_q[cur_idx];
                    end else begin
                        state_d         = FILL_REQ;
                        mem_req_write_d = 1'b0;
                        mem_req_addr_d  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_req_ready) begin
                    state_d         = FILL_REQ;
                    mem_req_write_d = 1'b0;
                    mem_req_addr_d  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                end
            end
            FILL_REQ: begin
                if (mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_rdata_valid) begin
                    fill_we          = 1'b1;
                    valid_d[cur_idx] = 1'b1;
                    dirty_d[cur_idx] = 1'b0;
                    state_d          = COMPARE;
                    // The relookup after a fill always hits the line just written.
                    resp_valid_d     = 1'b1;
                    resp_rdata_d     = word_sel(mem_rdata, word_of(addr_q));
                    resp_hit_d       = !miss_q;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d         = (state_d == IDLE);
        mem_req_valid_d = (state_d == WRITEBACK) || (state_d == FILL_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            miss_q          <= 1'b0;
            ready_q         <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_hit_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
            valid_q         <= '0;
            dirty_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            write_q         <= write_d;
            miss_q          <= miss_d;
            ready_q         <= ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_hit_q      <= resp_hit_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_write_q <= mem_req_write_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            if (fill_we) begin
                tag_q[cur_idx]  <= tag_of(addr_q);
                data_q[cur_idx] <= mem_rdata;
            end
            if (word_we) data_q[cur_idx][{word_of(addr_q), 5'b0} +: 32] <= wdata_q;
        end
    end

    assign ready         = ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_hit      = resp_hit_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a response scoreboard and a line
// memory model that services fills and absorbs writebacks.
module tb_data_cache;
    logic         clk, reset;
    logic         req_valid, req_read, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic         ready, resp_valid, resp_hit;
    logic [31:0]  resp_rdata;
    logic         mem_req_valid, mem_req_write, mem_req_ready, mem_rdata_valid;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata, mem_rdata;
    logic [31:0]  hit_count, miss_count;

    data_cache #(.LINE_BYTES(16), .NUM_SETS(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic hit; logic chk_data; } exp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [127:0] wdata; } mreq_t;

    exp_t         exp_q[$];
    mreq_t        mlog[$];
    logic [127:0] mem_store [logic [31:0]];
    int           errors = 0;
    int           checks = 0;

    function automatic logic [31:0] dw(input logic [31:0] la, input int w);
        return 32'hC0DE_0000 ^ (la << 4) ^ 32'(w);
    endfunction

    function automatic logic [127:0] default_line(input logic [31:0] la);
        return {dw(la, 3), dw(la, 2), dw(la, 1), dw(la, 0)};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (mem_store.exists(la)) return mem_store[la];
        return default_line(la);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge in IDLE, service memory, and compare
    // the response against the scoreboard. Returns at a negedge in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_hit,
                          input logic [31:0] exp_data, input logic chk_data,
                          input int stall, output int lat);
        exp_t         e;
        mreq_t        m;
        logic         got, pend, prev_mv;
        logic [31:0]  fill_a;
        int           stall_left;
        req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
        e.data = exp_data; e.hit = exp_hit; e.chk_data = chk_data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        got = 1'b0; pend = 1'b0; prev_mv = 1'b0; stall_left = stall; lat = 0; fill_a = '0;
        for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; req_valid = 1'b0; req_read = 1'b0;
            if (pend) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = mem_line(fill_a);
                pend = 1'b0;
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = cyc;
                chk("exp_q_size", 128'(exp_q.size()), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_hit", 128'(resp_hit), 128'(e.hit));
                    if (e.chk_data) chk("resp_rdata", 128'(resp_rdata), 128'(e.data));
                end
            end
            if (mem_req_valid) begin
                if (!prev_mv) begin
                    m.wr = mem_req_write; m.addr = mem_req_addr; m.wdata = mem_req_wdata;
                    mlog.push_back(m);
                end else begin
                    chk("hold_addr", 128'(mem_req_addr), 128'(m.addr));
                    chk("hold_write", 128'(mem_req_write), 128'(m.wr));
                    if (m.wr) chk("hold_wdata", mem_req_wdata, m.wdata);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    chk("stall_ready", 128'(ready), 128'(0));
                    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h0000_0300;
                end else begin
                    mem_req_ready = 1'b1;
                    if (mem_req_write) mem_store[mem_req_addr] = mem_req_wdata;
                    else begin pend = 1'b1; fill_a = mem_req_addr; end
                end
            end
            prev_mv = mem_req_valid && !mem_req_ready;
        end
        chk("resp_seen", 128'(got), 128'(1));
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; req_valid = 1'b0; req_read = 1'b0;
        chk("resp_one_cycle", 128'(resp_valid), 128'(0));
    endtask

    initial begin
        int           lat, n;
        logic [127:0] wb_line;
        reset = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_resp_rdata", 128'(resp_rdata), 128'(0));
        chk("rst_resp_hit", 128'(resp_hit), 128'(0));
        chk("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_mem_write", 128'(mem_req_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_req_addr), 128'(0));
        chk("rst_mem_wdata", mem_req_wdata, 128'(0));
        chk("rst_hits", 128'(hit_count), 128'(0));
        chk("rst_misses", 128'(miss_count), 128'(0));
        reset = 1'b0;

        // Cold read miss
        mlog.delete();
        access(1'b1, 1'b0, 32'h0000_0104, '0, 1'b0, dw(32'h100, 1), 1'b1, 0, lat);
        chk("cold_nreq", 128'(mlog.size()), 128'(1));
        if (mlog.size() > 0) begin
            chk("cold_fill_wr", 128'(mlog[0].wr), 128'(0));
            chk("cold_fill_addr", 128'(mlog[0].addr), 128'(32'h100));
        end
        chk("cold_misses", 128'(miss_count), 128'(1));
        chk("cold_hits", 128'(hit_count), 128'(0));

        // Read hit
        mlog.delete();
        access(1'b1, 1'b0, 32'h0000_0104, '0, 1'b1, dw(32'h100, 1), 1'b1, 0, lat);
        chk("hit_latency", 128'(lat), 128'(1));
        chk("hit_nreq", 128'(mlog.size()), 128'(0));
        chk("hit_hits", 128'(hit_count), 128'(1));

        // Write hit
        access(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b1, '0, 1'b0, 0, lat);
        chk("whit_latency", 128'(lat), 128'(1));
        chk("whit_hits", 128'(hit_count), 128'(2));

        // Dirty eviction with the writeback stalled for 5 cycles
        mlog.delete();
        access(1'b1, 1'b0, 32'h0000_1104, '0, 1'b0, dw(32'h1100, 1), 1'b1, 5, lat);
        wb_line = {dw(32'h100, 3), dw(32'h100, 2), 32'hDEAD_BEEF, dw(32'h100, 0)};
        chk("evict_nreq", 128'(mlog.size()), 128'(2));
        if (mlog.size() >= 2) begin
            chk("wb_wr", 128'(mlog[0].wr), 128'(1));
            chk("wb_addr", 128'(mlog[0].addr), 128'(32'h100));
            chk("wb_wdata", mlog[0].wdata, wb_line);
            chk("fill_wr", 128'(mlog[1].wr), 128'(0));
            chk("fill_addr", 128'(mlog[1].addr), 128'(32'h1100));
        end
        chk("evict_misses", 128'(miss_count), 128'(2));

        // Re-read the evicted line: the written-back store comes back
        mlog.delete();
        access(1'b1, 1'b0, 32'h0000_0104, '0, 1'b0, 32'hDEAD_BEEF, 1'b1, 0, lat);
        chk("refill_nreq", 128'(mlog.size()), 128'(1));
        if (mlog.size() > 0) chk("refill_wr", 128'(mlog[0].wr), 128'(0));
        chk("refill_misses", 128'(miss_count), 128'(3));

        // Read and write both set: the store must land
        access(1'b1, 1'b1, 32'h0000_0108, 32'h1234_5678, 1'b1, '0, 1'b0, 0, lat);
        access(1'b1, 1'b0, 32'h0000_0108, '0, 1'b1, 32'h1234_5678, 1'b1, 0, lat);
        chk("both_hits", 128'(hit_count), 128'(4));

        // Neither read nor write: ignored
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h0000_0104;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("nop_ready", 128'(ready), 128'(1));
        repeat (3) begin
            @(negedge clk);
            chk("nop_resp", 128'(resp_valid), 128'(0));
        end

        // Reset while waiting for fill data
        req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h0000_2234;
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 10) begin @(negedge clk); n++; end
        chk("mf_req_seen", 128'(mem_req_valid), 128'(1));
        chk("mf_req_addr", 128'(mem_req_addr), 128'(32'h2230));
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mf_mem_drop", 128'(mem_req_valid), 128'(0));
        chk("mf_ready", 128'(ready), 128'(1));
        mem_rdata_valid = 1'b1; mem_rdata = default_line(32'h2230);
        @(posedge clk); #1;
        mem_rdata_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mf_no_resp", 128'(resp_valid), 128'(0));
            chk("mf_no_mem", 128'(mem_req_valid), 128'(0));
        end
        chk("mf_hits", 128'(hit_count), 128'(0));
        chk("mf_misses", 128'(miss_count), 128'(0));

        mlog.delete();
        access(1'b1, 1'b0, 32'h0000_2234, '0, 1'b0, dw(32'h2230, 1), 1'b1, 0, lat);
        chk("mf_re_nreq", 128'(mlog.size()), 128'(1));
        if (mlog.size() > 0) chk("mf_re_addr", 128'(mlog[0].addr), 128'(32'h2230));

        // Dirty line at 0x100 was discarded by reset: plain fill, old word 2
        mlog.delete();
        access(1'b1, 1'b0, 32'h0000_0108, '0, 1'b0, dw(32'h100, 2), 1'b1, 0, lat);
        chk("disc_nreq", 128'(mlog.size()), 128'(1));
        if (mlog.size() > 0) chk("disc_wr", 128'(mlog[0].wr), 128'(0));
        chk("disc_misses", 128'(miss_count), 128'(2));
        chk("final_exp_q", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
